// File: rtl/sat_pkg.sv
// Shared types and constants for the DPLL SAT core.
package sat_pkg;

  localparam int unsigned NUM_VARIABLE     = 128;
  localparam int unsigned VARIABLE_INDEXES = 8;
  localparam int unsigned IDX_W            = VARIABLE_INDEXES + 1;

  typedef logic [IDX_W-1:0] var_idx_t;

  // Trace entry kinds
  localparam logic TT_DECIDE = 1'b0;
  localparam logic TT_FORCED = 1'b1;

  typedef enum logic [1:0] {
    VS_UNASSIGNED = 2'b00,
    VS_FALSE      = 2'b10,
    VS_TRUE       = 2'b11
  } var_state_t;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StWait,
    StCheck,
    StPush,
    StFin,
    StUnsat
  } bt_state_t;

  // Assignment-memory encoding of a boolean value
  function automatic var_state_t bool_state(input logic val);
    return val ? VS_TRUE : VS_FALSE;
  endfunction

endpackage

// File: rtl/backtrack_unit_if.sv
// Control, trace-table, assignment-memory and resume signals of the backtracker.
interface backtrack_unit_if;
  import sat_pkg::*;

  logic       start;
  logic       flush;
  logic       busy;
  logic       done;
  logic       unsat;
  var_idx_t   pop_count;

  logic       tt_en;
  logic       tt_rw;
  logic       tt_type_in;
  logic       tt_val_in;
  var_idx_t   tt_variable;
  logic       tt_type_out;
  logic       tt_val_out;
  var_idx_t   tt_variable_out;
  logic       tt_empty;

  logic       va_we;
  var_idx_t   va_var;
  var_state_t va_state;

  logic       resume_valid;
  var_idx_t   resume_var;
  logic       resume_val;

  // Backtracker side
  modport master (
    input  start, flush, tt_type_out, tt_val_out, tt_variable_out, tt_empty,
    output busy, done, unsat, pop_count,
    output tt_en, tt_rw, tt_type_in, tt_val_in, tt_variable,
    output va_we, va_var, va_state,
    output resume_valid, resume_var, resume_val
  );

  // Surrounding core (implication stage, trace table, assignment memory)
  modport slave (
    output start, flush, tt_type_out, tt_val_out, tt_variable_out, tt_empty,
    input  busy, done, unsat, pop_count,
    input  tt_en, tt_rw, tt_type_in, tt_val_in, tt_variable,
    input  va_we, va_var, va_state,
    input  resume_valid, resume_var, resume_val
  );

endinterface

// File: rtl/backtrack_unit.sv
// Chronological backtracker: unwinds the trace to the most recent DECIDE entry,
// re-pushes it as FORCED with the opposite value and hands the flip onward.
module backtrack_unit
  import sat_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  backtrack_unit_if.master  bus
);

  bt_state_t state;
  var_idx_t  pop_count;
  logic      pv_type;
  logic      pv_val;
  var_idx_t  pv_var;

  // FSM, pop counter and latched popped entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      pop_count <= '0;
      pv_type   <= 1'b0;
      pv_val    <= 1'b0;
      pv_var    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (!bus.flush && bus.start) begin
            if (bus.tt_empty) begin
              state <= StUnsat;
            end else begin
              state     <= StPop;
              pop_count <= '0;
            end
          end
        end
        StPop: begin
          if (pop_count != '1) pop_count <= pop_count + var_idx_t'(1);
          state <= bus.flush ? StIdle : StWait;
        end
        StWait: begin
          pv_type <= bus.tt_type_out;
          pv_val  <= bus.tt_val_out;
          pv_var  <= bus.tt_variable_out;
          state   <= bus.flush ? StIdle : StCheck;
        end
        StCheck: begin
          // Occupancy already reflects the pop issued two cycles earlier
          if (bus.flush)                 state <= StIdle;
          else if (pv_type == TT_DECIDE) state <= StPush;
          else if (bus.tt_empty)         state <= StUnsat;
          else                           state <= StPop;
        end
        StPush:  state <= bus.flush ? StIdle : StFin;
        StFin:   state <= StIdle;
        StUnsat: state <= StUnsat;
        default: state <= StIdle;
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.unsat        = 1'b0;
    bus.pop_count    = pop_count;
    bus.tt_en        = 1'b0;
    bus.tt_rw        = 1'b0;
    bus.tt_type_in   = 1'b0;
    bus.tt_val_in    = 1'b0;
    bus.tt_variable  = '0;
    bus.va_we        = 1'b0;
    bus.va_var       = '0;
    bus.va_state     = VS_UNASSIGNED;
    bus.resume_valid = 1'b0;
    bus.resume_var   = '0;
    bus.resume_val   = 1'b0;
    unique case (state)
      StIdle: ;
      StPop: begin
        bus.busy  = 1'b1;
        bus.tt_en = 1'b1;
      end
      StWait: bus.busy = 1'b1;
      StCheck: begin
        bus.busy     = 1'b1;
        bus.va_we    = 1'b1;
        bus.va_var   = pv_var;
        bus.va_state = VS_UNASSIGNED;
      end
      StPush: begin
        bus.busy        = 1'b1;
        bus.tt_en       = 1'b1;
        bus.tt_rw       = 1'b1;
        bus.tt_type_in  = TT_FORCED;
        bus.tt_val_in   = ~pv_val;
        bus.tt_variable = pv_var;
        bus.va_we       = 1'b1;
        bus.va_var      = pv_var;
        bus.va_state    = bool_state(~pv_val);
      end
      StFin: begin
        bus.busy         = 1'b1;
        bus.done         = 1'b1;
        bus.resume_valid = 1'b1;
        bus.resume_var   = pv_var;
        bus.resume_val   = ~pv_val;
      end
      StUnsat: bus.unsat = 1'b1;
      default: ;
    endcase
  end

endmodule
